// File: rtl/link_sequencer_if.sv
// Frame handshake and serial link pins of link_sequencer.
// Defining AUTO_RUN_EN adds the free-running 'run' input.
interface link_sequencer_if;
  logic         start;
  logic [127:0] tx_frame;
  logic         busy;
  logic         done;
  logic [127:0] rx_frame;
  logic         link_clk;
  logic         link_sync;
  logic         link_txbit;
  logic         link_rxbit;
  logic         cpu_clk;
`ifdef AUTO_RUN_EN
  logic         run;
`endif

  modport master (
`ifdef AUTO_RUN_EN
    input  run,
`endif
    input  start, tx_frame, link_rxbit,
    output busy, done, rx_frame, link_clk, link_sync, link_txbit, cpu_clk
  );

  modport slave (
`ifdef AUTO_RUN_EN
    output run,
`endif
    output start, tx_frame, link_rxbit,
    input  busy, done, rx_frame, link_clk, link_sync, link_txbit, cpu_clk
  );
endinterface

// File: rtl/link_sequencer.sv
// Board-side serial host link master: shifts four 32-bit slots each way, then pulses cpu_clk once.
// Optional AUTO_RUN_EN: 'run' starts frames back to back without 'start'.
module link_sequencer #(
  parameter int DIV     = 2,
  parameter int STEP_HI = 4,
  parameter int STEP_LO = 4
) (
  input  logic             clk_board,
  input  logic             sys_reset,
  link_sequencer_if.master bus
);

  localparam int STEP_MAX = (STEP_HI > STEP_LO) ? STEP_HI : STEP_LO;
  localparam int DIV_W    = $clog2(DIV) + 1;
  localparam int STEP_W   = $clog2(STEP_MAX) + 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [STEP_W-1:0] HI_LAST  = STEP_W'(STEP_HI - 1);
  localparam logic [STEP_W-1:0] LO_LAST  = STEP_W'(STEP_LO - 1);

  typedef enum logic [2:0] {
    IDLE, SH_LO, SH_HI, SY_LO, SY_HI, STEP_H, STEP_L, DONE
  } state_t;

  state_t state, state_next;

  logic [DIV_W-1:0]  div_cnt;
  logic [4:0]        bit_cnt;
  logic [1:0]        slot;
  logic [STEP_W-1:0] step_cnt;
  logic [127:0]      shadow;
  logic [31:0]       rx_word;
  logic [127:0]      rx_frame_q;
  logic              go;
  logic              div_last;
  logic              step_last;
  logic              link_phase;

`ifdef AUTO_RUN_EN
  assign go = bus.start | bus.run;
`else
  assign go = bus.start;
`endif

  assign link_phase = (state == SH_LO) || (state == SH_HI) ||
                      (state == SY_LO) || (state == SY_HI);
  assign div_last   = (div_cnt == DIV_LAST);
  assign step_last  = (state == STEP_H) ? (step_cnt == HI_LAST) : (step_cnt == LO_LAST);

  always_ff @(posedge clk_board) begin
    if (sys_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go)        state_next = SH_LO;
      SH_LO:   if (div_last)  state_next = SH_HI;
      SH_HI:   if (div_last)  state_next = (bit_cnt == 5'd31) ? SY_LO : SH_LO;
      SY_LO:   if (div_last)  state_next = SY_HI;
      SY_HI:   if (div_last)  state_next = (slot == 2'd3) ? STEP_H : SH_LO;
      STEP_H:  if (step_last) state_next = STEP_L;
      STEP_L:  if (step_last) state_next = DONE;
      DONE:                   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Every phase ends exactly on its terminal count, so counters never wrap past it.
  always_ff @(posedge clk_board) begin
    if (sys_reset) begin
      div_cnt    <= '0;
      step_cnt   <= '0;
      bit_cnt    <= '0;
      slot       <= '0;
      shadow     <= '0;
      rx_word    <= '0;
      rx_frame_q <= '0;
    end else begin
      if (link_phase && !div_last) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
      end

      if (((state == STEP_H) || (state == STEP_L)) && !step_last) begin
        step_cnt <= step_cnt + 1'b1;
      end else begin
        step_cnt <= '0;
      end

      case (state)
        IDLE: begin
          if (go) begin
            shadow  <= bus.tx_frame;
            slot    <= '0;
            bit_cnt <= '0;
          end
        end
        SH_LO: begin
          if (div_last) begin
            rx_word[bit_cnt] <= bus.link_rxbit;
          end
        end
        SH_HI: begin
          if (div_last && (bit_cnt != 5'd31)) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        SY_HI: begin
          if (div_last) begin
            rx_frame_q[{slot, 5'd0} +: 32] <= rx_word;
            bit_cnt <= '0;
            if (slot != 2'd3) begin
              slot <= slot + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // txbit is held through SH_HI so it is stable across the rising link clock.
  always_comb begin
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.link_clk   = 1'b0;
    bus.link_sync  = 1'b0;
    bus.link_txbit = 1'b0;
    bus.cpu_clk    = 1'b0;
    case (state)
      SH_LO: begin
        bus.busy       = 1'b1;
        bus.link_txbit = shadow[{slot, bit_cnt}];
      end
      SH_HI: begin
        bus.busy       = 1'b1;
        bus.link_clk   = 1'b1;
        bus.link_txbit = shadow[{slot, bit_cnt}];
      end
      SY_LO: begin
        bus.busy      = 1'b1;
        bus.link_sync = 1'b1;
      end
      SY_HI: begin
        bus.busy      = 1'b1;
        bus.link_sync = 1'b1;
        bus.link_clk  = 1'b1;
      end
      STEP_H: begin
        bus.busy    = 1'b1;
        bus.cpu_clk = 1'b1;
      end
      STEP_L:  bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.rx_frame = rx_frame_q;

endmodule

// File: tb/tb_link_sequencer.sv
// Scoreboard bench for link_sequencer: expected tx/rx words are queued at launch, checked at done.
`timescale 1ns/1ps
module tb_link_sequencer;

  localparam int DIV       = 2;
  localparam int STEP_HI   = 4;
  localparam int STEP_LO   = 4;
  localparam int FRAME_LEN = 4 * (33 * 2 * DIV) + STEP_HI + STEP_LO + 1;
  localparam int STEP_AT   = 4 * (33 * 2 * DIV) + 1;
  localparam int BUDGET    = 2000;

  logic clk_board = 1'b0;
  logic sys_reset = 1'b1;
  int   rx_mode   = 0;

  link_sequencer_if bus();

  assign bus.link_rxbit = (rx_mode == 2) ? bus.link_txbit : (rx_mode == 1);

  link_sequencer #(.DIV(DIV), .STEP_HI(STEP_HI), .STEP_LO(STEP_LO)) dut (
    .clk_board (clk_board),
    .sys_reset (sys_reset),
    .bus       (bus.master)
  );

  always #5 clk_board = ~clk_board;

  int tests = 0;
  int fails = 0;

  // Monitor: rebuilds words sent on the link and counts link/cpu events.
  logic        prev_lclk, prev_sync, prev_txbit, prev_cpu;
  logic [31:0] cur_word;
  int          bit_idx;
  logic [31:0] obs_log [0:255];
  int obs_cnt = 0, data_rises = 0, sync_rises = 0, sync_glitches = 0, done_total = 0, cpu_rises = 0;

  always @(negedge clk_board) begin
    if (sys_reset) begin
      bit_idx    <= 0;
      cur_word   <= '0;
      prev_lclk  <= 1'b0;
      prev_sync  <= 1'b0;
      prev_txbit <= 1'b0;
      prev_cpu   <= 1'b0;
    end else begin
      if (bus.link_clk && !prev_lclk) begin
        if (bus.link_sync) begin
          obs_log[obs_cnt % 256] <= cur_word;
          obs_cnt    <= obs_cnt + 1;
          sync_rises <= sync_rises + 1;
          bit_idx    <= 0;
        end else begin
          if (bit_idx < 32) cur_word[bit_idx] <= prev_txbit;
          bit_idx    <= bit_idx + 1;
          data_rises <= data_rises + 1;
        end
      end
      if (prev_lclk && bus.link_clk && (bus.link_sync !== prev_sync)) sync_glitches <= sync_glitches + 1;
      if (bus.done) done_total <= done_total + 1;
      if (bus.cpu_clk && !prev_cpu) cpu_rises <= cpu_rises + 1;
      prev_lclk  <= bus.link_clk;
      prev_sync  <= bus.link_sync;
      prev_txbit <= bus.link_txbit;
      prev_cpu   <= bus.cpu_clk;
    end
  end

  logic [31:0]  exp_tx_q[$];
  logic [127:0] exp_rx_q[$];
  int   rd_ptr = 0;
  logic hold_start = 1'b0;
  int   data_base, sync_base, done_base, cpu_base, glitch_base;
  int   cpu_first, cpu_last, cpu_hi_cycles, syncs_at_cpu;
`ifdef AUTO_RUN_EN
  int   drop_run_at = 0;
`endif

  task automatic launch(input logic [127:0] tx, input int mode, input logic use_start, input logic hold);
    logic [127:0] rx_exp;
    rx_mode = mode;
    bus.tx_frame = tx;
    if (use_start) bus.start = 1'b1;
    hold_start = hold;
    for (int s = 0; s < 4; s++) exp_tx_q.push_back(tx[32*s +: 32]);
    rx_exp = (mode == 2) ? tx : ((mode == 1) ? {128{1'b1}} : 128'd0);
    exp_rx_q.push_back(rx_exp);
    data_base   = data_rises;
    sync_base   = sync_rises;
    done_base   = done_total;
    cpu_base    = cpu_rises;
    glitch_base = sync_glitches;
  endtask

  task automatic await_done(output int lat);
    int           cnt;
    logic         seen;
    logic [127:0] exp_rx;
    logic [31:0]  exp_w, got_w;
    cnt = 0; seen = 1'b0;
    cpu_first = -1; cpu_last = -1; cpu_hi_cycles = 0; syncs_at_cpu = -1;
    while (!seen && cnt < BUDGET) begin
      @(negedge clk_board);
      cnt++;
      if (cnt == 1 && !hold_start) bus.start = 1'b0;
`ifdef AUTO_RUN_EN
      if (cnt == drop_run_at) bus.run = 1'b0;
`endif
      if (bus.cpu_clk) begin
        if (cpu_first < 0) begin
          cpu_first    = cnt;
          syncs_at_cpu = sync_rises - sync_base;
        end
        cpu_last = cnt;
        cpu_hi_cycles++;
      end
      if (bus.done) seen = 1'b1;
    end
    lat = seen ? cnt : -1;
    tests++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL done_timeout: no done within %0d cycles", BUDGET);
      bus.start = 1'b0;
    end else begin
      exp_rx = (exp_rx_q.size() > 0) ? exp_rx_q.pop_front() : 'x;
      tests++;
      if (bus.rx_frame !== exp_rx) begin
        fails++;
        $display("[TB] FAIL rx_frame: got %h expected %h", bus.rx_frame, exp_rx);
      end
      for (int s = 0; s < 4; s++) begin
        exp_w = (exp_tx_q.size() > 0) ? exp_tx_q.pop_front() : 'x;
        got_w = (rd_ptr < obs_cnt) ? obs_log[rd_ptr % 256] : 'x;
        rd_ptr++;
        tests++;
        if (got_w !== exp_w) begin
          fails++;
          $display("[TB] FAIL tx_slot%0d: got %h expected %h", s, got_w, exp_w);
        end
      end
    end
  endtask

  task automatic test_reset();
    int cnt, activity;
    sys_reset = 1'b1; bus.start = 1'b0; bus.tx_frame = '0; rx_mode = 1;
    repeat (3) @(negedge clk_board);
    tests++;
    if ({bus.busy, bus.done, bus.link_clk, bus.link_sync, bus.link_txbit, bus.cpu_clk} !== 6'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %b expected 000000",
               {bus.busy, bus.done, bus.link_clk, bus.link_sync, bus.link_txbit, bus.cpu_clk});
    end
    tests++;
    if (bus.rx_frame !== 128'd0) begin
      fails++; $display("[TB] FAIL reset_rx_frame: got %h expected 0", bus.rx_frame);
    end
    sys_reset = 1'b0;
    @(negedge clk_board);
    bus.tx_frame = {4{32'hFFFF_FFFF}};
    bus.start = 1'b1;
    @(negedge clk_board);
    bus.start = 1'b0;
    cnt = 1;
    while (cnt < 267) begin
      @(negedge clk_board);
      cnt++;
    end
    tests++;
    if (bus.link_clk !== 1'b1) begin
      fails++; $display("[TB] FAIL mid_frame_link_clk: got %b expected 1", bus.link_clk);
    end
    tests++;
    if (bus.rx_frame[63:0] !== {64{1'b1}}) begin
      fails++; $display("[TB] FAIL mid_frame_rx: got %h expected all ones", bus.rx_frame[63:0]);
    end
    sys_reset = 1'b1;
    repeat (3) @(negedge clk_board);
    sys_reset = 1'b0;
    @(negedge clk_board);
    tests++;
    if ({bus.busy, bus.done, bus.link_clk, bus.link_sync, bus.link_txbit, bus.cpu_clk} !== 6'b0) begin
      fails++;
      $display("[TB] FAIL abort_outputs: got %b expected 000000",
               {bus.busy, bus.done, bus.link_clk, bus.link_sync, bus.link_txbit, bus.cpu_clk});
    end
    tests++;
    if (bus.rx_frame !== 128'd0) begin
      fails++; $display("[TB] FAIL abort_rx_frame: got %h expected 0", bus.rx_frame);
    end
    activity = 0;
    repeat (600) begin
      @(negedge clk_board);
      if (bus.busy || bus.done || bus.link_clk || bus.cpu_clk) activity++;
    end
    tests++;
    if (activity !== 0) begin
      fails++; $display("[TB] FAIL abort_stays_idle: got %0d active cycles expected 0", activity);
    end
    rd_ptr = obs_cnt;
  endtask

  task automatic test_single_frame();
    int lat;
    @(negedge clk_board);
    launch({32'h0, 32'h0, 32'h0, 32'h0000_0001}, 1, 1'b1, 1'b0);
    await_done(lat);
    tests++;
    if (lat !== FRAME_LEN) begin
      fails++; $display("[TB] FAIL frame_latency: got %0d expected %0d", lat, FRAME_LEN);
    end
    @(negedge clk_board);
    tests++;
    if (data_rises - data_base !== 128) begin
      fails++; $display("[TB] FAIL data_clk_rises: got %0d expected 128", data_rises - data_base);
    end
    tests++;
    if (sync_rises - sync_base !== 4) begin
      fails++; $display("[TB] FAIL sync_clk_rises: got %0d expected 4", sync_rises - sync_base);
    end
    tests++;
    if (done_total - done_base !== 1) begin
      fails++; $display("[TB] FAIL done_pulses: got %0d expected 1", done_total - done_base);
    end
    tests++;
    if (sync_glitches - glitch_base !== 0) begin
      fails++; $display("[TB] FAIL sync_while_clk_high: got %0d expected 0", sync_glitches - glitch_base);
    end
  endtask

  task automatic test_lsb_first();
    int lat;
    @(negedge clk_board);
    launch({32'h0, 32'hDEAD_BEEF, 32'hA5A5_0F0F, 32'h1234_5678}, 2, 1'b1, 1'b0);
    await_done(lat);
    tests++;
    if (bus.rx_frame[63:32] !== 32'hA5A5_0F0F) begin
      fails++; $display("[TB] FAIL loopback_slot1: got %h expected a5a50f0f", bus.rx_frame[63:32]);
    end
  endtask

  task automatic test_step_pulse();
    int lat;
    @(negedge clk_board);
    launch({$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1'b1, 1'b0);
    await_done(lat);
    tests++;
    if (cpu_first !== STEP_AT) begin
      fails++; $display("[TB] FAIL cpu_clk_start: got %0d expected %0d", cpu_first, STEP_AT);
    end
    tests++;
    if (syncs_at_cpu !== 4) begin
      fails++; $display("[TB] FAIL cpu_clk_before_syncs: got %0d expected 4", syncs_at_cpu);
    end
    tests++;
    if (cpu_hi_cycles !== STEP_HI) begin
      fails++; $display("[TB] FAIL cpu_clk_high: got %0d expected %0d", cpu_hi_cycles, STEP_HI);
    end
    tests++;
    if (lat - cpu_last - 1 !== STEP_LO) begin
      fails++; $display("[TB] FAIL cpu_clk_low: got %0d expected %0d", lat - cpu_last - 1, STEP_LO);
    end
    @(negedge clk_board);
    tests++;
    if (cpu_rises - cpu_base !== 1) begin
      fails++; $display("[TB] FAIL cpu_clk_pulses: got %0d expected 1", cpu_rises - cpu_base);
    end
  endtask

  task automatic test_back_to_back();
    int lat, d0;
    d0 = done_total;
    @(negedge clk_board);
    launch({$urandom(), $urandom(), $urandom(), $urandom()}, 2, 1'b1, 1'b1);
    await_done(lat);
    tests++;
    if (lat !== FRAME_LEN) begin
      fails++; $display("[TB] FAIL held_start_latency: got %0d expected %0d", lat, FRAME_LEN);
    end
    @(negedge clk_board);
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++; $display("[TB] FAIL idle_after_done: busy got %b expected 0", bus.busy);
    end
    launch({$urandom(), $urandom(), $urandom(), $urandom()}, 2, 1'b1, 1'b0);
    await_done(lat);
    tests++;
    if (lat !== FRAME_LEN) begin
      fails++; $display("[TB] FAIL second_frame_latency: got %0d expected %0d", lat, FRAME_LEN);
    end
    @(negedge clk_board);
    tests++;
    if (done_total - d0 !== 2) begin
      fails++; $display("[TB] FAIL held_start_frames: got %0d expected 2", done_total - d0);
    end
  endtask

`ifdef AUTO_RUN_EN
  task automatic test_auto_run();
    int lat, d0, c0, activity;
    d0 = done_total;
    c0 = cpu_rises;
    @(negedge clk_board);
    bus.run = 1'b1;
    for (int f = 0; f < 4; f++) begin
      if (f > 0) begin
        @(negedge clk_board);
        tests++;
        if (bus.busy !== 1'b0) begin
          fails++; $display("[TB] FAIL auto_idle_gap%0d: busy got %b expected 0", f, bus.busy);
        end
      end
      drop_run_at = (f == 3) ? 100 : 0;
      launch({$urandom(), $urandom(), $urandom(), $urandom()}, 2, 1'b0, 1'b0);
      await_done(lat);
      tests++;
      if (lat !== FRAME_LEN) begin
        fails++; $display("[TB] FAIL auto_latency%0d: got %0d expected %0d", f, lat, FRAME_LEN);
      end
    end
    activity = 0;
    repeat (600) begin
      @(negedge clk_board);
      if (bus.busy || bus.done || bus.link_clk || bus.cpu_clk) activity++;
    end
    tests++;
    if (activity !== 0) begin
      fails++; $display("[TB] FAIL auto_stop_idle: got %0d active cycles expected 0", activity);
    end
    tests++;
    if (done_total - d0 !== 4) begin
      fails++; $display("[TB] FAIL auto_done_pulses: got %0d expected 4", done_total - d0);
    end
    tests++;
    if (cpu_rises - c0 !== 4) begin
      fails++; $display("[TB] FAIL auto_cpu_pulses: got %0d expected 4", cpu_rises - c0);
    end
  endtask
`endif

  initial begin
    bus.start    = 1'b0;
    bus.tx_frame = '0;
`ifdef AUTO_RUN_EN
    bus.run      = 1'b0;
`endif
    test_reset();
    test_single_frame();
    test_lsb_first();
    test_step_pulse();
    test_back_to_back();
`ifdef AUTO_RUN_EN
    test_auto_run();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
